// File: rtl/kbd_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 key decoder.
package kbd_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Default key codes (space is plain, arrows are E0-extended)
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // 50 ms at 50 MHz between a prefix byte and the byte that follows it
  localparam int TIMEOUT_DEFAULT = 2_500_000;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_state_t;

endpackage

// File: rtl/keyboard_key_state.sv
// Turns the PS/2 set-2 byte stream into held-key levels for the arrows and
// space, plus a per-frame sticky fire request so short space taps survive.
module keyboard_key_state
  import kbd_pkg::*;
#(
  parameter logic [7:0] KEY_SPACE      = SC_SPACE,
  parameter logic [7:0] KEY_LEFT       = SC_LEFT,
  parameter logic [7:0] KEY_RIGHT      = SC_RIGHT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  input  logic       startOfFrame,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic       fireReq
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  kbd_state_t       state;
  kbd_state_t       nextState;
  logic [CNT_W-1:0] cnt;

  logic makeSpace, breakSpace;
  logic makeLeft, breakLeft;
  logic makeRight, breakRight;
  logic timedOut;

  // Decode which key event, if any, the current byte completes
  always_comb begin
    makeSpace  = din_new && (state == IDLE)    && (din == KEY_SPACE);
    breakSpace = din_new && (state == BRK)     && (din == KEY_SPACE);
    makeLeft   = din_new && (state == EXT)     && (din == KEY_LEFT);
    breakLeft  = din_new && (state == EXT_BRK) && (din == KEY_LEFT);
    makeRight  = din_new && (state == EXT)     && (din == KEY_RIGHT);
    breakRight = din_new && (state == EXT_BRK) && (din == KEY_RIGHT);
    timedOut   = (state != IDLE) && (cnt == CNT_LAST);
  end

  // Next-state logic: bytes drive the walk, timeout abandons a stale prefix
  always_comb begin
    nextState = state;
    if (din_new) begin
      case (state)
        IDLE: begin
          if (din == SC_EXT)      nextState = EXT;
          else if (din == SC_BRK) nextState = BRK;
          else                    nextState = IDLE;
        end
        EXT: begin
          if (din == SC_BRK)      nextState = EXT_BRK;
          else if (din == SC_EXT) nextState = EXT;
          else                    nextState = IDLE;
        end
        default:                  nextState = IDLE;
      endcase
    end else if (timedOut) begin
      nextState = IDLE;
    end
  end

  // Sequence state and prefix timeout counter (counter idles at zero)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      if (din_new || (state == IDLE) || timedOut) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
    end
  end

  // Held-key levels; make sets, break clears, repeats leave them at 1
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      spaceBar   <= 1'b0;
      leftArrow  <= 1'b0;
      rightArrow <= 1'b0;
    end else begin
      if (makeSpace)       spaceBar   <= 1'b1;
      else if (breakSpace) spaceBar   <= 1'b0;
      if (makeLeft)        leftArrow  <= 1'b1;
      else if (breakLeft)  leftArrow  <= 1'b0;
      if (makeRight)       rightArrow <= 1'b1;
      else if (breakRight) rightArrow <= 1'b0;
    end
  end

  // Sticky fire: only a fresh press sets it, and a set beats the frame clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fireReq <= 1'b0;
    end else if (makeSpace && !spaceBar) begin
      fireReq <= 1'b1;
    end else if (startOfFrame) begin
      fireReq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keyboard_key_state.sv
// Directed bench for keyboard_key_state: a vector table for byte sequences
// plus hand-written sequences for latency, typematic, timeout and reset.
module tb_keyboard_key_state;

  localparam int TMO = 100;

  logic       clk;
  logic       resetN;
  logic [7:0] din;
  logic       din_new;
  logic       startOfFrame;
  logic       rightArrow, leftArrow, spaceBar, fireReq;

  int passed = 0;
  int total  = 0;

  keyboard_key_state #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .din          (din),
    .din_new      (din_new),
    .startOfFrame (startOfFrame),
    .rightArrow   (rightArrow),
    .leftArrow    (leftArrow),
    .spaceBar     (spaceBar),
    .fireReq      (fireReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bytes: up to three, first byte in [23:16]; exp = {right,left,space,fire}
  typedef struct {
    logic [23:0] bytes;
    int          n;
    logic        sof;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {r,l,s,f}=%b expected %b", name, act, exp);
  endtask

  function automatic logic [3:0] outs();
    return {rightArrow, leftArrow, spaceBar, fireReq};
  endfunction

  // Present one byte for a single clock; returns at the negedge after capture
  task automatic sendByte(input logic [7:0] b, input logic sof);
    @(negedge clk);
    din = b;
    din_new = 1'b1;
    startOfFrame = sof;
    @(negedge clk);
    din_new = 1'b0;
    startOfFrame = 1'b0;
    din = 8'h00;
  endtask

  task automatic pulseSof();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    idle(2);
    resetN = 1'b1;
    idle(1);
  endtask

  initial begin
    logic [7:0] b;

    resetN = 1'b0;
    din = 8'h00;
    din_new = 1'b0;
    startOfFrame = 1'b0;

    vecs[0]  = '{24'h000000, 0, 1'b0, 4'b0000}; // reset state
    vecs[1]  = '{24'h290000, 1, 1'b0, 4'b0011}; // space make
    vecs[2]  = '{24'h000000, 0, 1'b1, 4'b0010}; // frame clears fire
    vecs[3]  = '{24'hF02900, 2, 1'b0, 4'b0000}; // space break
    vecs[4]  = '{24'hE07400, 2, 1'b0, 4'b1000}; // right make
    vecs[5]  = '{24'hE06B00, 2, 1'b0, 4'b1100}; // left make
    vecs[6]  = '{24'hE0F074, 3, 1'b0, 4'b0100}; // right break
    vecs[7]  = '{24'h740000, 1, 1'b0, 4'b0100}; // plain 74 ignored
    vecs[8]  = '{24'hE07400, 2, 1'b0, 4'b1100}; // right make again
    vecs[9]  = '{24'hF07400, 2, 1'b0, 4'b1100}; // plain break of 74 ignored
    vecs[10] = '{24'h6B0000, 1, 1'b0, 4'b1100}; // plain 6B ignored
    vecs[11] = '{24'hE0F06B, 3, 1'b0, 4'b1000}; // left break
    vecs[12] = '{24'hE0F074, 3, 1'b0, 4'b0000}; // right break
    vecs[13] = '{24'hE0E06B, 3, 1'b0, 4'b0100}; // repeated E0 keeps EXT
    vecs[14] = '{24'hE01274, 3, 1'b0, 4'b0100}; // other byte drops to IDLE
    vecs[15] = '{24'hF0E06B, 3, 1'b0, 4'b0100}; // E0 after F0 drops to IDLE

    idle(3);
    resetN = 1'b1;
    idle(1);

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        b = vecs[i].bytes[23 - 8*k -: 8];
        sendByte(b, 1'b0);
      end
      if (vecs[i].sof) pulseSof();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Space latency: not visible on the capture cycle, visible one clk later
    doReset();
    @(negedge clk);
    din = 8'h29;
    din_new = 1'b1;
    #1 check("space_before_edge", outs(), 4'b0000);
    @(negedge clk);
    din_new = 1'b0;
    check("space_after_edge", outs(), 4'b0011);
    idle(500);
    check("space_held_500", outs(), 4'b0011);
    sendByte(8'hF0, 1'b0);
    check("space_mid_break", outs(), 4'b0011);
    sendByte(8'h29, 1'b0);
    check("space_released", outs(), 4'b0001);
    pulseSof();
    check("fire_cleared", outs(), 4'b0000);

    // Typematic: one fire per press despite repeated makes
    sendByte(8'h29, 1'b0);
    check("typ_first", outs(), 4'b0011);
    pulseSof();
    check("typ_cleared", outs(), 4'b0010);
    for (int k = 0; k < 4; k++) begin
      sendByte(8'h29, 1'b0);
      check($sformatf("typ_repeat%0d", k), outs(), 4'b0010);
    end
    sendByte(8'hF0, 1'b0);
    sendByte(8'h29, 1'b0);
    check("typ_release", outs(), 4'b0000);

    // Timeout: stale E0 is abandoned, so the 74 is a plain byte
    sendByte(8'hE0, 1'b0);
    idle(TMO);
    sendByte(8'h74, 1'b0);
    check("timeout_expired", outs(), 4'b0000);
    sendByte(8'hE0, 1'b0);
    idle(TMO / 2);
    sendByte(8'h74, 1'b0);
    check("timeout_within", outs(), 4'b1000);
    // Timed-out break prefix leaves level untouched
    sendByte(8'hE0, 1'b0);
    sendByte(8'hF0, 1'b0);
    idle(TMO + 5);
    sendByte(8'h74, 1'b0);
    check("timeout_break", outs(), 4'b1000);

    // Collision: press and frame strobe in the same cycle, set wins
    sendByte(8'h29, 1'b1);
    check("collision", outs(), 4'b1011);

    // Reset between E0 and F0 clears everything at once
    sendByte(8'hE0, 1'b0);
    @(negedge clk);
    resetN = 1'b0;
    #1 check("async_reset", outs(), 4'b0000);
    @(negedge clk);
    resetN = 1'b1;
    sendByte(8'hF0, 1'b0);
    sendByte(8'h74, 1'b0);
    check("post_reset_break", outs(), 4'b0000);
    sendByte(8'h74, 1'b0);
    check("post_reset_plain74", outs(), 4'b0000);
    sendByte(8'hE0, 1'b0);
    sendByte(8'h74, 1'b0);
    check("post_reset_make", outs(), 4'b1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
